// File: rtl/bus_select_arb.sv
// Registered N:1 source selector for the shared internal data bus.
// Fixed-index or round-robin grant, valid/ready on every channel and on the output.
module bus_select_arb #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src,
    output logic [CNT_W-1:0]        xfer_count
);
    // Handshake: a beat moves on a rising edge where valid and ready are both high.
    // in_ready is a function of in_valid/mode/sel/rr_ptr/output state only, never of in_data.

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_out_src;
    logic [CNT_W-1:0] r_xfer_count;
    logic [SEL_W-1:0] r_rr_ptr;

    logic             w_free;
    logic             w_grant_ok;
    logic [SEL_W-1:0] w_grant_idx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_grant_data;
    logic [SEL_W-1:0] w_next_ptr;
    int               w_best_d;
    int               w_d;

    assign w_free = !r_out_valid || out_ready;

    always_comb begin
        w_grant_ok  = 1'b0;
        w_grant_idx = '0;
        w_best_d    = NUM_IN;
        w_d         = 0;
        if (!mode) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    w_grant_ok  = 1'b1;
                    w_grant_idx = SEL_W'(i);
                end
            end
        end else begin
            // Pick the valid channel with the smallest wrapped distance from the pointer.
            for (int i = 0; i < NUM_IN; i++) begin
                w_d = i - int'(r_rr_ptr);
                if (w_d < 0) w_d = w_d + NUM_IN;
                if (in_valid[i] && w_d < w_best_d) begin
                    w_best_d    = w_d;
                    w_grant_ok  = 1'b1;
                    w_grant_idx = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        w_grant_data = '0;
        in_ready     = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_grant_idx == SEL_W'(i)) begin
                w_grant_data = in_data[i*WIDTH +: WIDTH];
                in_ready[i]  = !rst && w_free && w_grant_ok;
            end
        end
    end

    assign w_xfer     = w_free && w_grant_ok;
    assign w_next_ptr = (int'(w_grant_idx) == NUM_IN - 1) ? '0 : w_grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_src    <= '0;
            r_xfer_count <= '0;
            r_rr_ptr     <= '0;
        end else if (w_xfer) begin
            r_out_data   <= w_grant_data;
            r_out_src    <= w_grant_idx;
            r_out_valid  <= 1'b1;
            r_xfer_count <= r_xfer_count + 1'b1;
            if (mode) r_rr_ptr <= w_next_ptr;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign out_src    = r_out_src;
    assign xfer_count = r_xfer_count;
endmodule

// File: tb/tb_bus_select_arb.sv
// Directed bench for bus_select_arb: a 4-channel instance and a 3-channel, 4-bit-counter instance.
module tb_bus_select_arb;
    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_src;
    logic [15:0] xfer_count;

    logic        b_rst;
    logic [23:0] b_in_data;
    logic [2:0]  b_in_valid;
    logic [2:0]  b_in_ready;
    logic        b_mode;
    logic [1:0]  b_sel;
    logic [7:0]  b_out_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [1:0]  b_out_src;
    logic [3:0]  b_xfer_count;

    int n_chk  = 0;
    int n_fail = 0;

    bus_select_arb #(.WIDTH(8), .NUM_IN(4), .SEL_W(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_src(out_src), .xfer_count(xfer_count)
    );

    bus_select_arb #(.WIDTH(8), .NUM_IN(3), .SEL_W(2), .CNT_W(4)) dut_b (
        .clk(clk), .rst(b_rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .mode(b_mode), .sel(b_sel), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_src(b_out_src), .xfer_count(b_xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = 4'b1111; mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
        b_rst = 1'b1; b_in_data = 24'h02_01_00; b_in_valid = 3'b000; b_mode = 1'b0; b_sel = 2'd0;
        b_out_ready = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 4'b0000);
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_src", out_src, 0);
        chk("rst_count", xfer_count, 0);
        rst = 1'b0; b_rst = 1'b0;

        // Fixed select of channel 2
        in_data = 32'h00_C3_00_00; in_valid = 4'b0100; sel = 2'd2;
        #1 chk("fix_in_ready", in_ready, 4'b0100);
        step();
        chk("fix_data", out_data, 8'hC3);
        chk("fix_src", out_src, 2);
        chk("fix_valid", out_valid, 1);
        chk("fix_count", xfer_count, 1);

        // sel points at an idle channel: consume without refill
        sel = 2'd3;
        #1 chk("fix_idle_ready", in_ready, 4'b0000);
        step();
        chk("fix_idle_valid", out_valid, 0);
        chk("fix_idle_hold", out_data, 8'hC3);
        chk("fix_idle_count", xfer_count, 1);

        // Round-robin, all channels valid, pointer starts at 0
        mode = 1'b1; in_data = 32'h13_12_11_10; in_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_src", out_src, k % 4);
            chk("rr_data", out_data, 8'h10 + (k % 4));
            chk("rr_valid", out_valid, 1);
        end
        chk("rr_count", xfer_count, 7);

        // Back-pressure on beat from channel 1
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_in_ready", in_ready, 4'b0000);
            step();
            chk("bp_data", out_data, 8'h11);
            chk("bp_src", out_src, 1);
            chk("bp_valid", out_valid, 1);
        end
        chk("bp_count", xfer_count, 7);

        // Release with fixed sel=1: consume and refill in one cycle
        out_ready = 1'b1; mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; in_data = 32'h00_00_77_00;
        #1 chk("refill_ready", in_ready, 4'b0010);
        step();
        chk("refill_valid", out_valid, 1);
        chk("refill_data", out_data, 8'h77);
        chk("refill_count", xfer_count, 8);

        // Sparse round-robin: pointer is 2, only ch0/ch1 valid
        mode = 1'b1; in_valid = 4'b0011; in_data = 32'h00_00_21_20;
        #1 chk("sparse_ready0", in_ready, 4'b0001);
        step();
        chk("sparse_src0", out_src, 0);
        chk("sparse_data0", out_data, 8'h20);
        #1 chk("sparse_ready1", in_ready, 4'b0010);
        step();
        chk("sparse_src1", out_src, 1);
        chk("sparse_data1", out_data, 8'h21);
        chk("sparse_count", xfer_count, 10);

        in_valid = 4'b0000;
        step();
        chk("drain_valid", out_valid, 0);
        chk("drain_hold", out_data, 8'h21);

        // Load 0x5A, stall it, then reset mid-stall
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data = 32'h00_00_00_5A;
        step();
        in_valid = 4'b0000; out_ready = 1'b0;
        step();
        chk("stall_data", out_data, 8'h5A);
        chk("stall_valid", out_valid, 1);
        rst = 1'b1; in_valid = 4'b1111;
        #1 chk("rst2_in_ready", in_ready, 4'b0000);
        step();
        chk("rst2_valid", out_valid, 0);
        chk("rst2_data", out_data, 0);
        chk("rst2_src", out_src, 0);
        chk("rst2_count", xfer_count, 0);
        rst = 1'b0; mode = 1'b1; out_ready = 1'b1;
        #1 chk("rst2_ptr", in_ready, 4'b0001);

        // 3-channel instance: out-of-range sel never grants
        b_sel = 2'd3; b_in_valid = 3'b111;
        for (int k = 0; k < 3; k++) begin
            #1 chk("oor_ready", b_in_ready, 3'b000);
            step();
            chk("oor_valid", b_out_valid, 0);
        end
        chk("oor_count", b_xfer_count, 0);

        // 17 transfers on a 4-bit counter wrap to 1
        b_sel = 2'd0; b_in_valid = 3'b001;
        for (int k = 0; k < 17; k++) step();
        chk("wrap_count", b_xfer_count, 1);

        // Round-robin wraps at NUM_IN-1 = 2
        b_mode = 1'b1; b_in_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr3_src", b_out_src, k % 3);
            chk("rr3_data", b_out_data, k % 3);
        end
        chk("rr3_count", b_xfer_count, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_select_arb.md
Name: bus_select_arb

Overview:
- Parametrised successor to the CPU's fixed 2:1 8-bit data-path mux.
- Selects one of NUM_IN WIDTH-bit source channels onto a single registered destination bus, using valid/ready handshakes.
- Two modes: fixed select, where software or control drives the index, and round-robin arbitration among requesting sources.
- Sits between register-file/ALU/memory read ports and the shared internal data bus.

Parameters:
- WIDTH, 8, data bits per channel.
- NUM_IN, 4, number of source channels (2..16).
- SEL_W, 2, width of sel and out_src; must satisfy 2^SEL_W >= NUM_IN.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel data-valid.
- in_ready  output  NUM_IN  per-channel accept; combinational; at most one bit high.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  out_data holds an unconsumed beat.
- out_ready  input  1  downstream accepts beat.
- out_src  output  SEL_W  index of the channel that produced out_data.
- xfer_count  output  CNT_W  number of beats accepted from inputs since reset.

Behaviour:
- Reset: synchronous, active-high. One cycle of rst=1 clears all state:
  - out_valid=0, out_data=0, out_src=0, xfer_count=0, rr_ptr=0.
  - in_ready is forced to all-zero while rst=1.
  - A held beat is discarded; no handshake completes in a reset cycle.
- free = !out_valid | out_ready. The output register may load when free=1.
- Grant when mode=0:
  - grant = sel if sel < NUM_IN and in_valid[sel]=1; otherwise no grant.
  - sel >= NUM_IN never grants.
- Grant when mode=1:
  - Scan in_valid starting at rr_ptr, ascending, wrapping at NUM_IN-1 -> 0.
  - The first valid channel found is granted.
- in_ready[grant] = free & grant_exists. All other in_ready bits are 0.
- Transfer on the edge where in_valid[g] & in_ready[g]:
  - out_data <= channel g data; out_src <= g; out_valid <= 1.
  - xfer_count increments by 1 and wraps from 2^CNT_W-1 to 0.
  - If mode=1: rr_ptr <= (g+1) mod NUM_IN.
- rr_ptr changes only on a mode=1 transfer. Fixed-mode transfers leave it unchanged.
- Consume without refill: out_valid & out_ready with no grant -> out_valid <= 0. out_data and out_src hold their last values.
- Simultaneous consume and refill: the new beat loads in the same cycle. Throughput is 1 beat/cycle with no bubble.
- Stall: out_valid & !out_ready -> out_data, out_src and out_valid are held stable; all in_ready are 0.
- Latency: accepted input beat appears on out_data the next cycle.
- Switching mode or sel mid-stream affects only the next grant decision. A held beat is unaffected.
- Round-robin fairness: with all channels continuously valid and out_ready=1, grants follow ptr, ptr+1, ... mod NUM_IN. No channel waits more than NUM_IN-1 transfers.
- in_ready must not depend combinationally on in_data. It may depend on in_valid, mode, sel, out_valid, out_ready and rr_ptr.

Test Plan (WIDTH=8, NUM_IN=4):
- Reset check: assert rst mid-stall with out_valid=1, out_data=0x5A -> next cycle out_valid=0, out_data=0x00, xfer_count=0, in_ready=4'b0000.
- Fixed select: mode=0, sel=2, ch2=0xC3 valid, out_ready=1 -> in_ready=4'b0100; next cycle out_data=0xC3, out_src=2, xfer_count=1. Repeat with sel=3 and in_valid[3]=0 -> no transfer, out_valid drops to 0.
- Round-robin: mode=1, all valid with ch0..3 = 0x10, 0x11, 0x12, 0x13, out_ready=1 for 6 cycles -> out_src sequence 0,1,2,3,0,1 with out_data matching each source; xfer_count=6.
- Back-pressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_src unchanged, in_ready=0. Then out_ready=1 with ch1 valid -> consume and refill in the same cycle, out_valid stays 1.
- Sparse round-robin: rr_ptr=2, only ch0 and ch1 valid -> ch0 granted, rr_ptr becomes 1; next grant is ch1.
- Counter wrap: with CNT_W=4, make 17 transfers -> xfer_count reads 1. With sel=3'b… out-of-range (sel=3, NUM_IN=3) -> no grant ever.
